// File: rtl/button_conditioner.sv
// button_conditioner: turns raw, bouncy, active-low push-button pins into
// clean synchronous debounced active-low levels, plus a one-cycle press pulse
// for every button channel. Channels are fully independent of each other.
//
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat press pulses.
// When BTN_REPEAT_EN is defined, a button that stays held first repeats after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// Without BTN_REPEAT_EN, the REPEAT_* parameters only affect the counter width.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] press_p
);

  // The counter is wide enough for the largest terminal count, so it never wraps.
  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_RELEASE_CHK
  } state_e;

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] btn_n_q, btn_n_d;
  logic [NUM_BTN-1:0] press_p_q, press_p_d;
  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];
  logic [CW-1:0]      cnt_d   [NUM_BTN];

`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] REP_DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] REP_PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0]      rep_cnt_q   [NUM_BTN];
  logic [CW-1:0]      rep_cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] rep_first_q, rep_first_d;
`endif

  // Two-flop synchroniser per channel; the second stage is the sampled level.
  always_comb begin
    sync1_d = btn_raw_n;
    sync2_d = sync1_q;
  end

  // Per-channel debounce FSM, counters and output register next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_n_d   = btn_n_q;
    press_p_d = '0;
`ifdef BTN_REPEAT_EN
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rep_cnt_d[i] = '0;
    end
    rep_first_d = '1;
`endif
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      unique case (state_q[i])
        ST_RELEASED: begin
          btn_n_d[i] = 1'b1;
          if (!sync2_q[i]) begin
            state_d[i] = ST_PRESS_CHK;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_PRESS_CHK: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i]   = ST_PRESSED;
            cnt_d[i]     = '0;
            btn_n_d[i]   = 1'b0;
            press_p_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_PRESSED: begin
          btn_n_d[i] = 1'b0;
          if (sync2_q[i]) begin
            state_d[i] = ST_RELEASE_CHK;
            cnt_d[i]   = CW'(1);
          end
`ifdef BTN_REPEAT_EN
          // Staying held: first repeat after the delay, then on the period.
          else if (rep_first_q[i]) begin
            if (rep_cnt_q[i] == REP_DELAY_LAST) begin
              press_p_d[i]   = 1'b1;
              rep_first_d[i] = 1'b0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
            end
          end else begin
            rep_first_d[i] = 1'b0;
            if (rep_cnt_q[i] == REP_PERIOD_LAST) begin
              press_p_d[i] = 1'b1;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
            end
          end
`endif
        end
        ST_RELEASE_CHK: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
            btn_n_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_RELEASED;
          cnt_d[i]   = '0;
          btn_n_d[i] = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset puts every channel in RELEASED with outputs idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      btn_n_q   <= '1;
      press_p_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      btn_n_q   <= btn_n_d;
      press_p_q <= press_p_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  // Repeat timers: held at zero/first-phase whenever a channel is not PRESSED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_first_q <= '1;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end
`endif

  assign btn_n   = btn_n_q;
  assign press_p = press_p_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (small debounce/repeat
// parameters so every corner is reachable in a few hundred cycles).
module tb_button_conditioner;

  localparam int NB = 4;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw_n;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] press_p;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw_n(btn_raw_n),
    .btn_n    (btn_n),
    .press_p  (press_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] exp_btn;
    logic [NB-1:0] exp_press;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_released();
    btn_raw_n = '1;
    for (int i = 0; i < 10; i++) step();
    check("settle_btn", btn_n, 4'b1111);
    check("settle_press", press_p, 4'b0000);
  endtask

  initial begin
    // Watchdog so the bench always terminates.
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Record i: raw applied after edge i, outputs checked after edge i+1.
    // bit0 clean press; bit1 bounces 3 low / 1 high / 3 low then releases.
    tbl[0]  = '{4'b1100, 4'b1111, 4'b0000};
    tbl[1]  = '{4'b1100, 4'b1111, 4'b0000};
    tbl[2]  = '{4'b1100, 4'b1111, 4'b0000};
    tbl[3]  = '{4'b1110, 4'b1111, 4'b0000};
    tbl[4]  = '{4'b1100, 4'b1111, 4'b0000};
    tbl[5]  = '{4'b1100, 4'b1110, 4'b0001};
    tbl[6]  = '{4'b1100, 4'b1110, 4'b0000};
    tbl[7]  = '{4'b1110, 4'b1110, 4'b0000};
    tbl[8]  = '{4'b1110, 4'b1110, 4'b0000};
    tbl[9]  = '{4'b1110, 4'b1110, 4'b0000};
    tbl[10] = '{4'b1110, 4'b1110, 4'b0000};
    tbl[11] = '{4'b1110, 4'b1110, 4'b0000};

    rst_n     = 1'b0;
    btn_raw_n = '1;
    #23;
    check("reset_btn", btn_n, 4'b1111);
    check("reset_press", press_p, 4'b0000);
    step();
    rst_n = 1'b1;

    // Idle: nothing pressed for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      step();
      check("idle_btn", btn_n, 4'b1111);
      check("idle_press", press_p, 4'b0000);
    end

    // Clean press on bit0 alongside bounce on bit1.
    for (int i = 0; i < 12; i++) begin
      btn_raw_n = tbl[i].raw;
      step();
      check($sformatf("tbl_btn[%0d]", i), btn_n, tbl[i].exp_btn);
      check($sformatf("tbl_press[%0d]", i), press_p, tbl[i].exp_press);
    end

    // Asynchronous reset mid-cycle while bit0 is pressed.
    btn_raw_n = '1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_btn", btn_n, 4'b1111);
    check("async_rst_press", press_p, 4'b0000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_btn", btn_n, 4'b1111);
    end

    // bit2: press, 2-cycle release glitch, then clean release latency.
    btn_raw_n = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      step();
      check("b2_press_btn", btn_n, (i < 5) ? 4'b1111 : 4'b1011);
      check("b2_press_p", press_p, (i == 5) ? 4'b0100 : 4'b0000);
    end
    btn_raw_n = 4'b1111;
    step();
    check("b2_glitch_btn", btn_n, 4'b1011);
    step();
    check("b2_glitch_btn", btn_n, 4'b1011);
    btn_raw_n = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      step();
      check("b2_glitch_btn", btn_n, 4'b1011);
      check("b2_glitch_press", press_p, 4'b0000);
    end
    btn_raw_n = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check("b2_release_btn", btn_n, (i < 5) ? 4'b1011 : 4'b1111);
      check("b2_release_press", press_p, 4'b0000);
    end
    settle_released();

    // Simultaneous press on bits 0 and 1.
    btn_raw_n = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      step();
      check("simul_btn", btn_n, (i < 5) ? 4'b1111 : 4'b1100);
      check("simul_press", press_p, (i == 5) ? 4'b0011 : 4'b0000);
    end
    settle_released();

    // bit3 held for 50 cycles: auto-repeat pulses only with the macro.
    for (int i = 0; i < 62; i++) begin
      logic [NB-1:0] exp_p;
      btn_raw_n = (i < 50) ? 4'b0111 : 4'b1111;
      step();
      exp_p = 4'b0000;
`ifdef BTN_REPEAT_EN
      if (i == 5 || i == 25 || i == 33 || i == 41 || i == 49) exp_p = 4'b1000;
`else
      if (i == 5) exp_p = 4'b1000;
`endif
      check($sformatf("hold_press[%0d]", i), press_p, exp_p);
      check($sformatf("hold_btn[%0d]", i), btn_n, (i >= 5 && i < 55) ? 4'b0111 : 4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
